// File: rtl/alu_pkg.sv
// Shared definitions for the ALU driver: op codes, compare encodings, FSM states
// and the response record captured from the ALU.
package alu_pkg;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_XOR = 2'b11;

  // Compare flags are packed as {a_gt_b, a_eq_b, a_lt_b}
  localparam logic [2:0] GT = 3'b100;
  localparam logic [2:0] EQ = 3'b010;
  localparam logic [2:0] LT = 3'b001;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    DRIVE = 2'b01,
    RESP  = 2'b10
  } drv_state_t;

  typedef struct packed {
    logic [3:0] y;
    logic       p;
    logic       ov;
    logic [2:0] cmp;
  } alu_rsp_t;

  function automatic logic parity4(input logic [3:0] v);
    return ^v;
  endfunction

  function automatic logic [2:0] cmp_enc(input logic [3:0] x, input logic [3:0] z);
    logic [2:0] c;
    if (x > z) begin
      c = GT;
    end else if (x == z) begin
      c = EQ;
    end else begin
      c = LT;
    end
    return c;
  endfunction

endpackage

// File: rtl/alu_ref_model.sv
// Reference ALU used by the driver's optional self-check: computes the result
// and flags the external ALU is expected to return for the driven operands.
module alu_ref_model
  import alu_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [1:0] f,
  output alu_rsp_t   exp_rsp
);

  logic [4:0] wide_s;
  logic [3:0] y_s;
  logic       ov_s;

  // Result and overflow per op code; overflow is the carry/borrow out of bit 3
  always_comb begin
    wide_s = 5'd0;
    y_s    = 4'd0;
    ov_s   = 1'b0;
    case (f)
      ALU_ADD: begin
        wide_s = {1'b0, a} + {1'b0, b};
        y_s    = wide_s[3:0];
        ov_s   = wide_s[4];
      end
      ALU_SUB: begin
        wide_s = {1'b0, a} - {1'b0, b};
        y_s    = wide_s[3:0];
        ov_s   = wide_s[4];
      end
      ALU_AND: begin
        y_s = a & b;
      end
      ALU_XOR: begin
        y_s = a ^ b;
      end
      default: begin
        y_s = 4'd0;
      end
    endcase
  end

  assign exp_rsp.y   = y_s;
  assign exp_rsp.p   = parity4(y_s);
  assign exp_rsp.ov  = ov_s;
  assign exp_rsp.cmp = cmp_enc(a, b);

endmodule

// File: rtl/alu_driver.sv
// alu_driver: issues one operation at a time to an external combinational ALU,
// holds operands for SETTLE_CYCLES, captures the result. Self-check under ALU_DRV_CHECK_EN.
module alu_driver
  import alu_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1  // legal range 1..15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [3:0] req_a,
  input  logic [3:0] req_b,
  input  logic [1:0] req_f,
  output logic [3:0] a,
  output logic [3:0] b,
  output logic [1:0] f,
  output logic       oe,
  input  logic [3:0] y,
  input  logic       p,
  input  logic       ov,
  input  logic       a_gt_b,
  input  logic       a_eq_b,
  input  logic       a_lt_b,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [3:0] rsp_y,
  output logic       rsp_p,
  output logic       rsp_ov,
  output logic [2:0] rsp_cmp,
  output logic [7:0] op_count,
  output logic       err
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  drv_state_t state_r;
  drv_state_t next_state_s;
  logic [3:0] settle_cnt_r;
  logic       accept_s;
  logic       capture_s;
  logic       rsp_done_s;
  logic [3:0] a_r;
  logic [3:0] b_r;
  logic [1:0] f_r;
  logic       oe_r;
  logic       req_ready_r;
  logic       rsp_valid_r;
  alu_rsp_t   rsp_r;
  alu_rsp_t   alu_in_s;
  logic [7:0] op_count_r;

  assign accept_s   = req_valid && req_ready_r;
  assign capture_s  = (state_r == DRIVE) && (settle_cnt_r == SETTLE_LAST);
  assign rsp_done_s = (state_r == RESP) && rsp_ready;
  assign alu_in_s   = {y, p, ov, a_gt_b, a_eq_b, a_lt_b};

  // Next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          next_state_s = DRIVE;
        end else begin
          next_state_s = IDLE;
        end
      end
      DRIVE: begin
        if (capture_s) begin
          next_state_s = RESP;
        end else begin
          next_state_s = DRIVE;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = RESP;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // State register; reset drops any in-flight operation
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Settle counter: counts DRIVE cycles, cleared everywhere else
  always_ff @(posedge clk) begin
    if (rst) begin
      settle_cnt_r <= 4'd0;
    end else if ((state_r == DRIVE) && !capture_s) begin
      settle_cnt_r <= settle_cnt_r + 4'd1;
    end else begin
      settle_cnt_r <= 4'd0;
    end
  end

  // Operand registers: loaded on accept, stable through DRIVE
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r <= 4'd0;
      b_r <= 4'd0;
      f_r <= 2'b00;
    end else if (accept_s) begin
      a_r <= req_a;
      b_r <= req_b;
      f_r <= req_f;
    end else begin
      a_r <= a_r;
      b_r <= b_r;
      f_r <= f_r;
    end
  end

  // Handshake/enable flags registered from the next state so they align with it
  always_ff @(posedge clk) begin
    if (rst) begin
      oe_r        <= 1'b0;
      req_ready_r <= 1'b0;
      rsp_valid_r <= 1'b0;
    end else begin
      oe_r        <= (next_state_s == DRIVE);
      req_ready_r <= (next_state_s == IDLE);
      rsp_valid_r <= (next_state_s == RESP);
    end
  end

  // Response capture on the last DRIVE edge; held until the next capture
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_r <= '0;
    end else if (capture_s) begin
      rsp_r <= alu_in_s;
    end else begin
      rsp_r <= rsp_r;
    end
  end

  // Completed-response counter, wraps naturally at 8 bits
  always_ff @(posedge clk) begin
    if (rst) begin
      op_count_r <= 8'd0;
    end else if (rsp_done_s) begin
      op_count_r <= op_count_r + 8'd1;
    end else begin
      op_count_r <= op_count_r;
    end
  end

`ifdef ALU_DRV_CHECK_EN
  alu_rsp_t exp_rsp_s;
  logic     mismatch_s;
  logic     err_r;

  alu_ref_model u_ref (
    .a       (a_r),
    .b       (b_r),
    .f       (f_r),
    .exp_rsp (exp_rsp_s)
  );

  assign mismatch_s = capture_s && (alu_in_s != exp_rsp_s);

  // Sticky mismatch flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      err_r <= 1'b0;
    end else if (mismatch_s) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  assign err = err_r;
`else
  assign err = 1'b0;
`endif

  assign req_ready = req_ready_r;
  assign a         = a_r;
  assign b         = b_r;
  assign f         = f_r;
  assign oe        = oe_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_y     = rsp_r.y;
  assign rsp_p     = rsp_r.p;
  assign rsp_ov    = rsp_r.ov;
  assign rsp_cmp   = rsp_r.cmp;
  assign op_count  = op_count_r;

endmodule
